if_priv_ctrl: RTL and testbench
===============================

IF_PRIV_CTRL -- requirements
Module: if_priv_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32: fetch PC width.
REQ-002 SHALL have parameter CNT_W, default 32: stall-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1: pipeline flush from commit.
REQ-006 SHALL have port pkt_valid, input, 1: predecoded fetch packet accepted this cycle.
REQ-007 SHALL have port pkt_pc, input, PC_W: PC of the accepted packet.
REQ-008 SHALL have ports ibar_flag, csr_flag and tlb_flag, input, 2 each: predecoder hits; bit0 = slot0, bit1 = slot1.
REQ-009 SHALL have ports ibar_flag_from_ex, csr_flag_from_ex and tlb_flag_from_ex, input, 1 each: instruction reached EX.
REQ-010 SHALL have ports icache_idle, dcache_idle, csr_done and tlb_done, input, 1 each.
REQ-011 SHALL have port fetch_hold, output, 1: stall and drain fetch.
REQ-012 SHALL have port set_pc_from_priv, output, 1: redirect fetch.
REQ-013 SHALL have port pc_from_priv, output, PC_W: redirect target.
REQ-014 SHALL have port stat, output, 3: current state.
REQ-015 SHALL have port stall_cycles, output, CNT_W: present only under the macro in REQ-031.

Function
REQ-016 SHALL use these state encodings:
- IDLE = 000
- WAIT_EX_IBAR = 001
- WAIT_EX_CSR = 010
- WAIT_CACHE_IDLE = 011
- WAIT_CSR_OK = 100
- WAIT_TLB_OK = 101
- WAIT_EX_TLB = 111
REQ-017 IDLE SHALL leave only when pkt_valid is high and a flag is nonzero.
- Flag priority: ibar, then csr, then tlb.
- Destinations: WAIT_EX_IBAR, WAIT_EX_CSR or WAIT_EX_TLB respectively.
REQ-018 On leaving IDLE, the block SHALL capture the redirect target from the winning flag.
- Bit0 set: target = pkt_pc+4.
- Bit1 only: target = pkt_pc+8.
- Addition is modulo 2^PC_W; 0xFFFFFFFC+8 wraps to 0x00000004.
REQ-019 Each WAIT_EX_* state SHALL advance only when its own *_from_ex is high.
- WAIT_EX_IBAR goes to WAIT_CACHE_IDLE.
- WAIT_EX_CSR goes to WAIT_CSR_OK.
- WAIT_EX_TLB goes to WAIT_TLB_OK.
- Every other *_from_ex input is ignored.
REQ-020 WAIT_CACHE_IDLE SHALL go to IDLE in the first cycle icache_idle and dcache_idle are both high.
REQ-021 WAIT_CSR_OK SHALL go to IDLE on csr_done, and WAIT_TLB_OK SHALL go to IDLE on tlb_done.
REQ-022 set_pc_from_priv SHALL be a registered one-cycle pulse in the cycle after each transition of REQ-020/021, with pc_from_priv valid in that cycle.
REQ-023 pc_from_priv SHALL hold its value until the next capture, flush or reset.
REQ-024 fetch_hold SHALL be combinational: high iff stat != IDLE.
REQ-025 In IDLE, flags arriving with pkt_valid low SHALL be ignored.
REQ-026 flush SHALL win over every other event, same cycle.
- Next state: IDLE.
- set_pc_from_priv is not raised, including a pulse pending for the next cycle.
- pc_from_priv is cleared to 0.
REQ-027 A done or idle input that arrives before its state is reached SHALL NOT be remembered; the state waits for a fresh assertion.
REQ-028 An illegal encoding (110) SHALL go to IDLE on the next cycle.

Reset
REQ-029 While rstn is low, all outputs SHALL take their reset values immediately, independent of clk:
- stat = IDLE
- fetch_hold = 0
- set_pc_from_priv = 0
- pc_from_priv = 0
- stall_cycles = 0
REQ-030 Reset mid-wait SHALL abandon the sequence with no redirect pulse after release.

Configuration
REQ-031 The macro IF_PRIV_STALL_CNT_EN SHALL control the stall counter.
- Defined: stall_cycles increments each cycle fetch_hold is high, saturating at all-ones.
- Defined: flush does not clear stall_cycles; only reset does.
- Undefined: the port, counter and logic are absent.

Structure
REQ-032 The state encodings and the INST_NOP and zero constants SHALL live in shared package fetch_pkg, also used by the IF1 FIFO.
REQ-033 The saturating counter SHALL be sub-module sat_counter (parameter W; ports clk, rstn, inc, q).
REQ-034 The FSM and the PC capture SHALL remain in this module.

Verification
REQ-035 ibar_flag=01, pkt_pc=0x1C000000, then ibar_flag_from_ex after 3 cycles, then both caches idle after 2 more cycles -> stat sequence 001, 011, 000; a single set_pc_from_priv pulse with pc_from_priv=0x1C000004; fetch_hold high throughout the wait.
REQ-036 csr_flag=10 with tlb_flag=01 in the same packet, pkt_pc=0x80 -> WAIT_EX_CSR; target 0x88; after csr_flag_from_ex then csr_done, one pulse; tlb_done is ignored throughout.
REQ-037 pkt_pc=0xFFFFFFFC with tlb_flag=10 -> target 0x00000004 after tlb_flag_from_ex and tlb_done.
REQ-038 flush in WAIT_CSR_OK in the same cycle as csr_done -> IDLE; no pulse; pc_from_priv=0.
REQ-039 With IF_PRIV_STALL_CNT_EN, CNT_W=4 and a 20-cycle hold -> stall_cycles saturates at 15; the build without the macro elaborates with no stall_cycles port.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch front end. The privileged-instruction
// fetch controller (if_priv_ctrl) and the IF1 FIFO both use it.
//   - priv_state_e : state encoding of the privileged fetch controller
//   - INST_NOP     : canonical NOP word (andi r0, r0, 0)
//   - ZERO_WORD    : all-zero 32-bit word
//   - FLAG_NONE    : "no predecoder hit" value for the 2-slot flag vectors
//   - redirect_offset() : byte offset from the packet PC to the first
//                         instruction after the flagged slot
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'b000,
        ST_WAIT_EX_IBAR    = 3'b001,
        ST_WAIT_EX_CSR     = 3'b010,
        ST_WAIT_CACHE_IDLE = 3'b011,
        ST_WAIT_CSR_OK     = 3'b100,
        ST_WAIT_TLB_OK     = 3'b101,
        ST_WAIT_EX_TLB     = 3'b111
    } priv_state_e;

    localparam logic [31:0] INST_NOP  = 32'h0340_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [1:0]  FLAG_NONE = 2'b00;

    // A hit in slot0 resumes at the slot1 instruction (pc+4); a hit only in
    // slot1 resumes after the whole two-instruction packet (pc+8).
    function automatic logic [3:0] redirect_offset(input logic [1:0] flag);
        return flag[0] ? 4'd4 : 4'd8;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset, clears the count
//   inc  : count one this cycle
//   q    : current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/if_priv_ctrl.sv
// -----------------------------------------------------------------------------
// if_priv_ctrl
// Fetch-side controller for privileged instructions (ibar, CSR and TLB ops).
// When the predecoder flags one in an accepted packet, fetch is held and
// drained. The controller waits for the instruction to reach EX and then for
// its side effect to complete (caches idle / csr_done / tlb_done). It then
// issues a one-cycle redirect to the instruction after the flagged one.
//
// Ports:
//   clk, rstn                 : clock (rising edge), async active-low reset
//   flush                     : commit flush; overrides everything
//   pkt_valid, pkt_pc         : accepted predecoded packet and its PC
//   ibar/csr/tlb_flag[1:0]    : predecoder hits, bit0 = slot0, bit1 = slot1
//   *_flag_from_ex            : the flagged instruction has reached EX
//   icache_idle, dcache_idle  : both caches quiescent (ibar completion)
//   csr_done, tlb_done        : CSR / TLB operation completion
//   fetch_hold                : stall and drain fetch (high outside IDLE)
//   set_pc_from_priv          : registered one-cycle redirect strobe
//   pc_from_priv              : redirect target, held until next capture
//   stat                      : current state encoding
//   stall_cycles              : saturating count of held cycles
//                               (only with IF_PRIV_STALL_CNT_EN defined)
//
// Build option: define IF_PRIV_STALL_CNT_EN to add the stall_cycles port
// and its counter. The counter is cleared only by reset, not by flush.
// -----------------------------------------------------------------------------
module if_priv_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             pkt_valid,
    input  logic [PC_W-1:0]  pkt_pc,
    input  logic [1:0]       ibar_flag,
    input  logic [1:0]       csr_flag,
    input  logic [1:0]       tlb_flag,
    input  logic             ibar_flag_from_ex,
    input  logic             csr_flag_from_ex,
    input  logic             tlb_flag_from_ex,
    input  logic             icache_idle,
    input  logic             dcache_idle,
    input  logic             csr_done,
    input  logic             tlb_done,
    output logic             fetch_hold,
    output logic             set_pc_from_priv,
    output logic [PC_W-1:0]  pc_from_priv,
    output logic [2:0]       stat
`ifdef IF_PRIV_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    priv_state_e     state_q;
    priv_state_e     state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            set_pc_q;
    logic            set_pc_d;
    logic [1:0]      win_flag;
    logic            pkt_hit;

    assign pkt_hit = pkt_valid && ((ibar_flag != FLAG_NONE) ||
                                   (csr_flag  != FLAG_NONE) ||
                                   (tlb_flag  != FLAG_NONE));

    // Done/idle inputs are looked at only in the state that waits for them,
    // so an early assertion is never latched.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        set_pc_d = 1'b0;
        win_flag = FLAG_NONE;

        case (state_q)
            ST_IDLE: begin
                if (pkt_hit) begin
                    if (ibar_flag != FLAG_NONE) begin
                        state_d  = ST_WAIT_EX_IBAR;
                        win_flag = ibar_flag;
                    end else if (csr_flag != FLAG_NONE) begin
                        state_d  = ST_WAIT_EX_CSR;
                        win_flag = csr_flag;
                    end else begin
                        state_d  = ST_WAIT_EX_TLB;
                        win_flag = tlb_flag;
                    end
                    // Wraps modulo 2^PC_W by construction.
                    pc_d = pkt_pc + PC_W'(redirect_offset(win_flag));
                end
            end
            ST_WAIT_EX_IBAR: begin
                if (ibar_flag_from_ex) begin
                    state_d = ST_WAIT_CACHE_IDLE;
                end
            end
            ST_WAIT_EX_CSR: begin
                if (csr_flag_from_ex) begin
                    state_d = ST_WAIT_CSR_OK;
                end
            end
            ST_WAIT_EX_TLB: begin
                if (tlb_flag_from_ex) begin
                    state_d = ST_WAIT_TLB_OK;
                end
            end
            ST_WAIT_CACHE_IDLE: begin
                if (icache_idle && dcache_idle) begin
                    state_d  = ST_IDLE;
                    set_pc_d = 1'b1;
                end
            end
            ST_WAIT_CSR_OK: begin
                if (csr_done) begin
                    state_d  = ST_IDLE;
                    set_pc_d = 1'b1;
                end
            end
            ST_WAIT_TLB_OK: begin
                if (tlb_done) begin
                    state_d  = ST_IDLE;
                    set_pc_d = 1'b1;
                end
            end
            default: begin
                // Unused encoding 3'b110 recovers to IDLE.
                state_d = ST_IDLE;
            end
        endcase

        // Flush cancels the sequence, any redirect about to be registered,
        // and the stored target.
        if (flush) begin
            state_d  = ST_IDLE;
            pc_d     = '0;
            set_pc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            set_pc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            set_pc_q <= set_pc_d;
        end
    end

    assign stat             = state_q;
    assign fetch_hold       = (state_q != ST_IDLE);
    assign set_pc_from_priv = set_pc_q;
    assign pc_from_priv     = pc_q;

`ifdef IF_PRIV_STALL_CNT_EN
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rstn(rstn),
        .inc (fetch_hold),
        .q   (stall_cycles)
    );
`else
    // Stall counter compiled out; CNT_W only kept for a uniform parameter list.
    if (CNT_W > 0) begin : g_stall_cnt_off
    end
`endif

endmodule

// File: tb/tb_if_priv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_priv_ctrl
// Directed scenarios plus a randomized run against a behavioural model that
// tracks the pending privileged operation as (kind, phase, target, pulse).
// -----------------------------------------------------------------------------
module tb_if_priv_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rstn;
    logic             flush;
    logic             pkt_valid;
    logic [PC_W-1:0]  pkt_pc;
    logic [1:0]       ibar_flag;
    logic [1:0]       csr_flag;
    logic [1:0]       tlb_flag;
    logic             ibar_flag_from_ex;
    logic             csr_flag_from_ex;
    logic             tlb_flag_from_ex;
    logic             icache_idle;
    logic             dcache_idle;
    logic             csr_done;
    logic             tlb_done;
    logic             fetch_hold;
    logic             set_pc_from_priv;
    logic [PC_W-1:0]  pc_from_priv;
    logic [2:0]       stat;
`ifdef IF_PRIV_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    // Model: kind 0=none 1=ibar 2=csr 3=tlb; phase 0=waiting for EX,
    // 1=waiting for completion.
    int          m_kind;
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_pulse;
    int          m_cnt;

    if_priv_ctrl #(
        .PC_W (PC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .flush            (flush),
        .pkt_valid        (pkt_valid),
        .pkt_pc           (pkt_pc),
        .ibar_flag        (ibar_flag),
        .csr_flag         (csr_flag),
        .tlb_flag         (tlb_flag),
        .ibar_flag_from_ex(ibar_flag_from_ex),
        .csr_flag_from_ex (csr_flag_from_ex),
        .tlb_flag_from_ex (tlb_flag_from_ex),
        .icache_idle      (icache_idle),
        .dcache_idle      (dcache_idle),
        .csr_done         (csr_done),
        .tlb_done         (tlb_done),
        .fetch_hold       (fetch_hold),
        .set_pc_from_priv (set_pc_from_priv),
        .pc_from_priv     (pc_from_priv),
        .stat             (stat)
`ifdef IF_PRIV_STALL_CNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_stat();
        case (m_kind)
            1:       return (m_phase != 0) ? 3'b011 : 3'b001;
            2:       return (m_phase != 0) ? 3'b100 : 3'b010;
            3:       return (m_phase != 0) ? 3'b101 : 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        m_kind  = 0;
        m_phase = 0;
        m_pc    = 32'h0;
        m_pulse = 1'b0;
        m_cnt   = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [1:0] f;
        f = 2'b00;
        if (m_kind != 0 && m_cnt < 15) m_cnt++;
        if (flush) begin
            m_kind  = 0;
            m_pc    = 32'h0;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (m_kind == 0) begin
                if (pkt_valid) begin
                    if (ibar_flag != 2'b00) begin
                        m_kind = 1; f = ibar_flag;
                    end else if (csr_flag != 2'b00) begin
                        m_kind = 2; f = csr_flag;
                    end else if (tlb_flag != 2'b00) begin
                        m_kind = 3; f = tlb_flag;
                    end
                    if (m_kind != 0) begin
                        m_phase = 0;
                        m_pc    = pkt_pc + (f[0] ? 32'd4 : 32'd8);
                    end
                end
            end else if (m_phase == 0) begin
                if ((m_kind == 1 && ibar_flag_from_ex) ||
                    (m_kind == 2 && csr_flag_from_ex) ||
                    (m_kind == 3 && tlb_flag_from_ex)) m_phase = 1;
            end else if ((m_kind == 1 && icache_idle && dcache_idle) ||
                         (m_kind == 2 && csr_done) ||
                         (m_kind == 3 && tlb_done)) begin
                m_kind  = 0;
                m_pulse = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        flush = 0; pkt_valid = 0; pkt_pc = '0;
        ibar_flag = 0; csr_flag = 0; tlb_flag = 0;
        ibar_flag_from_ex = 0; csr_flag_from_ex = 0; tlb_flag_from_ex = 0;
        icache_idle = 0; dcache_idle = 0; csr_done = 0; tlb_done = 0;
    endtask

    // Short async reset pulse placed between clock edges.
    task automatic pulse_reset();
        #1 rstn = 1'b0;
        model_reset();
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        tick();
        #1 rstn = 1'b0;
        model_reset();
        #1;
        total++; if (stat !== 3'b000) begin bad++; $display("FAIL reset_stat got=%b exp=000", stat); end
        total++; if (fetch_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b exp=0", fetch_hold); end
        total++; if (set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL reset_setpc got=%b exp=0", set_pc_from_priv); end
        total++; if (pc_from_priv !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_from_priv); end
`ifdef IF_PRIV_STALL_CNT_EN
        total++; if (stall_cycles !== 4'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
`endif
        rstn = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_ibar_seq();
        pulse_reset(); drive_idle();
        pkt_valid = 1; ibar_flag = 2'b01; pkt_pc = 32'h1C00_0000;
        tick(); drive_idle();
        total++; if (stat !== 3'b001 || fetch_hold !== 1'b1) begin bad++; $display("FAIL ibar_enter got stat=%b hold=%b exp 001/1", stat, fetch_hold); end
        total++; if (pc_from_priv !== 32'h1C00_0004) begin bad++; $display("FAIL ibar_capture got=%h exp=1c000004", pc_from_priv); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (stat !== 3'b001 || fetch_hold !== 1'b1 || set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL ibar_wait_ex got stat=%b hold=%b pulse=%b exp 001/1/0", stat, fetch_hold, set_pc_from_priv); end
        end
        ibar_flag_from_ex = 1; tick(); ibar_flag_from_ex = 0;
        total++; if (stat !== 3'b011) begin bad++; $display("FAIL ibar_to_cache got=%b exp=011", stat); end
        icache_idle = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (stat !== 3'b011 || fetch_hold !== 1'b1 || set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL ibar_one_cache got stat=%b hold=%b pulse=%b exp 011/1/0", stat, fetch_hold, set_pc_from_priv); end
        end
        dcache_idle = 1; tick(); drive_idle();
        total++; if (stat !== 3'b000 || fetch_hold !== 1'b0) begin bad++; $display("FAIL ibar_done got stat=%b hold=%b exp 000/0", stat, fetch_hold); end
        total++; if (set_pc_from_priv !== 1'b1 || pc_from_priv !== 32'h1C00_0004) begin bad++; $display("FAIL ibar_pulse got pulse=%b pc=%h exp 1/1c000004", set_pc_from_priv, pc_from_priv); end
        tick();
        total++; if (set_pc_from_priv !== 1'b0 || pc_from_priv !== 32'h1C00_0004) begin bad++; $display("FAIL ibar_after got pulse=%b pc=%h exp 0/1c000004", set_pc_from_priv, pc_from_priv); end
        $display("test_ibar_seq: done");
    endtask

    task automatic test_csr_prio();
        pulse_reset(); drive_idle();
        pkt_valid = 1; csr_flag = 2'b10; tlb_flag = 2'b01; pkt_pc = 32'h80;
        tick(); drive_idle();
        total++; if (stat !== 3'b010 || pc_from_priv !== 32'h88) begin bad++; $display("FAIL csr_enter got stat=%b pc=%h exp 010/88", stat, pc_from_priv); end
        tlb_done = 1; ibar_flag_from_ex = 1; tlb_flag_from_ex = 1; tick();
        total++; if (stat !== 3'b010) begin bad++; $display("FAIL csr_other_ex got=%b exp=010", stat); end
        ibar_flag_from_ex = 0; tlb_flag_from_ex = 0; csr_flag_from_ex = 1; tick(); csr_flag_from_ex = 0;
        total++; if (stat !== 3'b100) begin bad++; $display("FAIL csr_to_ok got=%b exp=100", stat); end
        tick();
        total++; if (stat !== 3'b100 || set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL csr_tlbdone_ignored got stat=%b pulse=%b exp 100/0", stat, set_pc_from_priv); end
        csr_done = 1; tick(); drive_idle();
        total++; if (stat !== 3'b000 || set_pc_from_priv !== 1'b1 || pc_from_priv !== 32'h88) begin bad++; $display("FAIL csr_pulse got stat=%b pulse=%b pc=%h exp 000/1/88", stat, set_pc_from_priv, pc_from_priv); end
        tick();
        total++; if (set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL csr_single_pulse got=%b exp=0", set_pc_from_priv); end
        $display("test_csr_prio: done");
    endtask

    task automatic test_tlb_wrap();
        pulse_reset(); drive_idle();
        pkt_valid = 1; tlb_flag = 2'b10; pkt_pc = 32'hFFFF_FFFC;
        tick(); drive_idle();
        total++; if (stat !== 3'b111 || pc_from_priv !== 32'h4) begin bad++; $display("FAIL tlb_enter got stat=%b pc=%h exp 111/00000004", stat, pc_from_priv); end
        tlb_flag_from_ex = 1; tick(); drive_idle();
        total++; if (stat !== 3'b101) begin bad++; $display("FAIL tlb_to_ok got=%b exp=101", stat); end
        tlb_done = 1; tick(); drive_idle();
        total++; if (stat !== 3'b000 || set_pc_from_priv !== 1'b1 || pc_from_priv !== 32'h4) begin bad++; $display("FAIL tlb_pulse got stat=%b pulse=%b pc=%h exp 000/1/00000004", stat, set_pc_from_priv, pc_from_priv); end
        $display("test_tlb_wrap: done");
    endtask

    task automatic test_flush();
        pulse_reset(); drive_idle();
        pkt_valid = 1; csr_flag = 2'b01; pkt_pc = 32'h100;
        tick(); drive_idle();
        csr_flag_from_ex = 1; tick(); drive_idle();
        total++; if (stat !== 3'b100 || pc_from_priv !== 32'h104) begin bad++; $display("FAIL flush_setup got stat=%b pc=%h exp 100/104", stat, pc_from_priv); end
        flush = 1; csr_done = 1; tick(); drive_idle();
        total++; if (stat !== 3'b000 || set_pc_from_priv !== 1'b0 || pc_from_priv !== 32'h0) begin bad++; $display("FAIL flush_win got stat=%b pulse=%b pc=%h exp 000/0/0", stat, set_pc_from_priv, pc_from_priv); end
        tick();
        total++; if (set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL flush_no_late_pulse got=%b exp=0", set_pc_from_priv); end
        flush = 1; pkt_valid = 1; ibar_flag = 2'b01; pkt_pc = 32'h500; tick(); drive_idle();
        total++; if (stat !== 3'b000 || pc_from_priv !== 32'h0) begin bad++; $display("FAIL flush_idle_pkt got stat=%b pc=%h exp 000/0", stat, pc_from_priv); end
        $display("test_flush: done");
    endtask

    task automatic test_ignore_and_early();
        pulse_reset(); drive_idle();
        ibar_flag = 2'b11; csr_flag = 2'b11; tlb_flag = 2'b11; pkt_pc = 32'h40;
        tick();
        total++; if (stat !== 3'b000 || fetch_hold !== 1'b0) begin bad++; $display("FAIL pv_low_ignored got stat=%b hold=%b exp 000/0", stat, fetch_hold); end
        drive_idle();
        pkt_valid = 1; ibar_flag = 2'b10; pkt_pc = 32'h200; icache_idle = 1; dcache_idle = 1;
        tick(); pkt_valid = 0; ibar_flag = 0;
        total++; if (stat !== 3'b001 || pc_from_priv !== 32'h208) begin bad++; $display("FAIL early_enter got stat=%b pc=%h exp 001/208", stat, pc_from_priv); end
        ibar_flag_from_ex = 1; tick(); drive_idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (stat !== 3'b011 || set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL early_not_kept got stat=%b pulse=%b exp 011/0", stat, set_pc_from_priv); end
        end
        icache_idle = 1; dcache_idle = 1; tick(); drive_idle();
        total++; if (stat !== 3'b000 || set_pc_from_priv !== 1'b1) begin bad++; $display("FAIL early_fresh got stat=%b pulse=%b exp 000/1", stat, set_pc_from_priv); end
        $display("test_ignore_and_early: done");
    endtask

    task automatic test_reset_mid_wait();
        pulse_reset(); drive_idle();
        pkt_valid = 1; tlb_flag = 2'b01; pkt_pc = 32'h300;
        tick(); drive_idle();
        tlb_flag_from_ex = 1; tick(); drive_idle();
        #1 rstn = 1'b0;
        model_reset();
        #1;
        total++; if (stat !== 3'b000 || fetch_hold !== 1'b0 || pc_from_priv !== 32'h0) begin bad++; $display("FAIL midreset_async got stat=%b hold=%b pc=%h exp 000/0/0", stat, fetch_hold, pc_from_priv); end
        rstn = 1'b1;
        tlb_done = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (stat !== 3'b000 || set_pc_from_priv !== 1'b0) begin bad++; $display("FAIL midreset_no_pulse got stat=%b pulse=%b exp 000/0", stat, set_pc_from_priv); end
        end
        drive_idle();
        $display("test_reset_mid_wait: done");
    endtask

    task automatic test_stall_cnt();
`ifdef IF_PRIV_STALL_CNT_EN
        pulse_reset(); drive_idle();
        pkt_valid = 1; ibar_flag = 2'b01; pkt_pc = 32'h0;
        tick(); drive_idle();
        for (int i = 0; i < 4; i++) tick();
        total++; if (stall_cycles !== 4'd4) begin bad++; $display("FAIL cnt_partial got=%0d exp=4", stall_cycles); end
        for (int i = 0; i < 16; i++) tick();
        total++; if (stall_cycles !== 4'd15) begin bad++; $display("FAIL cnt_saturate got=%0d exp=15", stall_cycles); end
        flush = 1; tick(); drive_idle();
        total++; if (stall_cycles !== 4'd15 || stat !== 3'b000) begin bad++; $display("FAIL cnt_flush_keeps got cnt=%0d stat=%b exp 15/000", stall_cycles, stat); end
        pulse_reset();
        total++; if (stall_cycles !== 4'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", stall_cycles); end
        $display("test_stall_cnt: done");
`else
        $display("test_stall_cnt: counter not built");
`endif
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = bad;
        pulse_reset(); drive_idle();
        for (int n = 0; n < 3000; n++) begin
            flush             = ($urandom_range(39) == 0);
            pkt_valid         = ($urandom_range(2) == 0);
            pkt_pc            = ($urandom_range(7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(7)))
                                                         : 32'($urandom);
            ibar_flag         = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom);
            csr_flag          = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom);
            tlb_flag          = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom);
            ibar_flag_from_ex = ($urandom_range(3) == 0);
            csr_flag_from_ex  = ($urandom_range(3) == 0);
            tlb_flag_from_ex  = ($urandom_range(3) == 0);
            icache_idle       = ($urandom_range(1) == 0);
            dcache_idle       = ($urandom_range(1) == 0);
            csr_done          = ($urandom_range(2) == 0);
            tlb_done          = ($urandom_range(2) == 0);
            if ($urandom_range(199) == 0) begin
                #1 rstn = 1'b0;
                model_reset();
                #1;
                total++; if (stat !== 3'b000 || fetch_hold !== 1'b0 || set_pc_from_priv !== 1'b0 || pc_from_priv !== 32'h0) begin bad++; $display("FAIL rnd_reset n=%0d got stat=%b hold=%b pulse=%b pc=%h exp all 0", n, stat, fetch_hold, set_pc_from_priv, pc_from_priv); end
                rstn = 1'b1;
            end
            tick();
            total++; if (stat !== exp_stat()) begin bad++; $display("FAIL rnd_stat n=%0d got=%b exp=%b", n, stat, exp_stat()); end
            total++; if (fetch_hold !== (m_kind != 0)) begin bad++; $display("FAIL rnd_hold n=%0d got=%b exp=%b", n, fetch_hold, (m_kind != 0)); end
            total++; if (set_pc_from_priv !== m_pulse) begin bad++; $display("FAIL rnd_pulse n=%0d got=%b exp=%b", n, set_pc_from_priv, m_pulse); end
            total++; if (pc_from_priv !== m_pc) begin bad++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc_from_priv, m_pc); end
`ifdef IF_PRIV_STALL_CNT_EN
            total++; if (stall_cycles !== 4'(m_cnt)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cycles, m_cnt); end
`endif
            if (bad - errs_before > 20) break;
        end
        drive_idle();
        $display("test_random: done");
    endtask

    initial begin
        rstn = 1'b0;
        drive_idle();
        model_reset();
        #12 rstn = 1'b1;
        test_reset();
        test_ibar_seq();
        test_csr_prio();
        test_tlb_wrap();
        test_flush();
        test_ignore_and_early();
        test_reset_mid_wait();
        test_stall_cnt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
